pwm_peripheral: RTL and testbench

- Downstream consumer of the SPI register file.
- Takes the five control registers (output enables, PWM enables, duty cycle) and drives 16 output pins.
- Each pin is either static low, static high, or a shared PWM waveform.
- The PWM period is 256 prescaled ticks; the duty cycle is common to all PWM-enabled pins.

---
 rtl/tt_regmap_pkg.sv | 22 ++
 rtl/pwm_prescaler.sv | 26 ++
 rtl/pwm_peripheral.sv | 81 ++++++++
 tb/tb_pwm_peripheral.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tt_regmap_pkg.sv
// Register map shared by the SPI register file and the PWM peripheral.
// Both blocks decode against these constants, so keep them in one place.
package tt_regmap_pkg;

  localparam int REG_W     = 8;
  localparam int NUM_PINS  = 16;
  localparam int PWM_CNT_W = 8;

  // Register addresses decoded by the SPI register file
  localparam logic [REG_W-1:0] ADDR_EN_OUT_7_0   = 8'h00;
  localparam logic [REG_W-1:0] ADDR_EN_OUT_15_8  = 8'h01;
  localparam logic [REG_W-1:0] ADDR_EN_PWM_7_0   = 8'h02;
  localparam logic [REG_W-1:0] ADDR_EN_PWM_15_8  = 8'h03;
  localparam logic [REG_W-1:0] ADDR_PWM_DUTY     = 8'h04;

  // Per-pin drive: disabled pins are low, enabled non-PWM pins are high,
  // enabled PWM pins follow the shared waveform.
  function automatic logic pin_drive(input logic oe, input logic pe, input logic level);
    return oe & (pe ? level : 1'b1);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: pulses tick for one clk every PRESCALE_DIV clk cycles.
// PRESCALE_DIV = 1 gives a tick on every cycle.
module pwm_prescaler #(
  parameter int unsigned PRESCALE_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE_DIV - 1);

  logic [15:0] pre_cnt;

  assign tick = (pre_cnt == LAST);

  // Count 0..PRESCALE_DIV-1 and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 16'd1;
  end

endmodule

// File: rtl/pwm_peripheral.sv
// PWM peripheral: drives 16 pins as static low, static high or a shared PWM
// waveform (period 256 prescaled ticks, common duty).
// Build option PWM_SHADOW_DUTY_EN: when defined, the duty value is latched
// only at the period boundary so mid-period writes never produce runt pulses;
// when undefined, the duty input feeds the comparator directly.
module pwm_peripheral
  import tt_regmap_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_W-1:0]    en_reg_out_7_0,
  input  logic [REG_W-1:0]    en_reg_out_15_8,
  input  logic [REG_W-1:0]    en_reg_pwm_7_0,
  input  logic [REG_W-1:0]    en_reg_pwm_15_8,
  input  logic [REG_W-1:0]    pwm_duty_cycle,
  output logic [NUM_PINS-1:0] out
);

  logic [NUM_PINS-1:0]  en_out;
  logic [NUM_PINS-1:0]  en_pwm;
  logic                 tick;
  logic                 boundary;
  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [REG_W-1:0]     duty_active;
  logic                 pwm_level;
  logic [NUM_PINS-1:0]  out_next;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_prescaler #(.PRESCALE_DIV(PRESCALE_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign boundary = tick && (pwm_cnt == '1);

  // Period counter: advances once per tick, wraps 255 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
  end

`ifdef PWM_SHADOW_DUTY_EN
  // Shadow duty: captured at the period boundary so each period uses one value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        duty_active <= '0;
    else if (boundary) duty_active <= pwm_duty_cycle;
  end
`else
  logic unused_boundary;
  assign unused_boundary = boundary;
  assign duty_active     = pwm_duty_cycle;
`endif

  // Compare: 0x00 is always low, 0xFF is always high, else cnt < duty.
  always_comb begin
    // NOTE: a default assignment first guarantees every path drives the
    // signal, so no latch is inferred.
    pwm_level = 1'b0;
    if (duty_active == '1)      pwm_level = 1'b1;
    else if (duty_active != '0) pwm_level = (pwm_cnt < duty_active);
  end

  // Per-pin output mux.
  always_comb begin
    out_next = '0;
    for (int i = 0; i < NUM_PINS; i++)
      out_next[i] = pin_drive(en_out[i], en_pwm[i], pwm_level);
  end

  // Registered pin drive: one clk of latency from enables and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= out_next;
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: random enable/duty stimulus against
// a cycle-indexed reference, plus high-time and period measurements.
module tb_pwm_peripheral;

  localparam int unsigned P   = 13;
  localparam int unsigned PER = 256 * P;
`ifdef PWM_SHADOW_DUTY_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out_v = 16'hFFFF;
  logic [15:0] en_pwm_v = 16'hFFFF;
  logic [7:0]  duty = 8'hFF;
  logic [15:0] out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: k = clk edges taken since reset release.
  int unsigned k = 0;
  logic [7:0]  shadow = 8'h00;
  logic [15:0] exp_out = 16'h0000;

  pwm_peripheral #(.PRESCALE_DIV(P)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out_v[7:0]),
    .en_reg_out_15_8 (en_out_v[15:8]),
    .en_reg_pwm_7_0  (en_pwm_v[7:0]),
    .en_reg_pwm_15_8 (en_pwm_v[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected pins for the edge whose pre-edge tick index is kk.
  function automatic logic [15:0] ref_out(input int unsigned kk, input logic [7:0] d,
                                          input logic [15:0] eo, input logic [15:0] ep);
    int unsigned phase;
    logic lvl;
    logic [15:0] r;
    phase = (kk / P) % 256;
    lvl   = (d == 8'hFF) ? 1'b1 : (phase < int'(d));
    for (int i = 0; i < 16; i++) r[i] = eo[i] & (ep[i] ? lvl : 1'b1);
    return r;
  endfunction

  // Reference model, advanced on each active edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0; shadow = 8'h00; exp_out = 16'h0000;
    end else begin
      exp_out = ref_out(k, SHADOW ? shadow : duty, en_out_v, en_pwm_v);
      if ((k % P == P - 1) && ((k / P) % 256 == 255)) shadow = duty;
      k++;
    end
  end

  // Cycle-by-cycle comparison on the inactive edge.
  always @(negedge clk) check("out_cycle", out, rst_n ? exp_out : 16'h0000);

  // Measure one full period aligned to pwm_cnt=0; optionally change duty mid-way.
  task automatic measure(input int chg_at, input logic [7:0] chg_val,
                         output int unsigned hi, output int unsigned all_hi, output logic first_bit);
    int t;
    hi = 0; all_hi = 0; first_bit = 1'b0;
    @(negedge clk);
    if (k % PER == 1) @(negedge clk);
    t = 0;
    while ((k % PER) != 1 && t < 2 * PER) begin
      @(negedge clk);
      t++;
    end
    check("align", k % PER, 1);
    for (int i = 0; i < int'(PER); i++) begin
      if (i == 0) first_bit = out[0];
      hi     += out[0];
      all_hi += (out == 16'hFFFF) ? 1 : 0;
      if (i == chg_at) duty = chg_val;
      if (i < int'(PER) - 1) @(negedge clk);
    end
  endtask

  initial begin
    int unsigned hi, all_hi, t1, t2;
    logic fb, prev;
    logic [7:0] sweep [5];
    sweep = '{8'h80, 8'h00, 8'h01, 8'hFE, 8'hFF};

    // Reset held with all inputs high
    repeat (3) @(negedge clk);
    check("rst_out", out, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", out, SHADOW ? 16'h0000 : 16'hFFFF);

    // Output enable only, no PWM
    en_out_v = 16'h00FF; en_pwm_v = 16'h0000;
    @(negedge clk);
    check("oe_only", out, 16'h00FF);
    repeat (20) @(negedge clk);
    check("oe_only_hold", out, 16'h00FF);

    // Random enable / duty traffic, checked cycle by cycle
    for (int n = 0; n < 1200; n++) begin
      if ($urandom_range(3) == 0) begin
        en_out_v = 16'($urandom);
        en_pwm_v = 16'($urandom);
        duty     = 8'($urandom);
      end
      @(negedge clk);
    end

    // Duty sweep with every pin on PWM
    en_out_v = 16'hFFFF; en_pwm_v = 16'hFFFF;
    foreach (sweep[j]) begin
      duty = sweep[j];
      measure(-1, 8'h00, hi, all_hi, fb);
      check($sformatf("high_%02h", sweep[j]), hi, (sweep[j] == 8'hFF) ? PER : sweep[j] * P);
      check($sformatf("all_pins_%02h", sweep[j]), all_hi, hi);
      if (sweep[j] == 8'h80) check("rise_at_cnt0", fb, 1'b1);
    end

    // Mid-period duty change 0x40 -> 0xC0 at pwm_cnt=100
    duty = 8'h40;
    measure(100 * P - 1, 8'hC0, hi, all_hi, fb);
    check("chg_period", hi, SHADOW ? 64 * P : 64 * P + (192 - 100) * P);
    measure(-1, 8'h00, hi, all_hi, fb);
    check("chg_next", hi, 192 * P);

    // Reset asserted mid-period with pins high
    en_pwm_v = 16'h0000;
    t1 = 0;
    while ((k % PER) != 200 * P + 1 && t1 < 2 * PER) begin
      @(negedge clk);
      t1++;
    end
    check("pre_rst_high", out, 16'hFFFF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", out, 16'h0000);
    repeat (3) @(negedge clk);
    en_pwm_v = 16'hFFFF; duty = 8'h80;
    rst_n = 1'b1;
    prev = 1'b0; t1 = 0; t2 = 0;
    for (int unsigned c = 1; c <= 3 * PER && t2 == 0; c++) begin
      @(negedge clk);
      if (out[0] && !prev) begin
        if (t1 == 0) t1 = c;
        else t2 = c;
      end
      prev = out[0];
    end
    check("first_rise", t1, SHADOW ? PER + 1 : 1);
    check("period_len", t2 - t1, PER);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
